fft_bf_scheduler: RTL and testbench
===================================

// Module: fft_bf_scheduler
// PURPOSE
//  Drives the radix-2 butterfly adder for an in-place N-point FFT: walks stages/groups/pairs,
//  issues operand-pair read addresses and twiddle index, asserts the adder's en/delay strobes,
//  and emits write-back addresses aligned to the adder result. One butterfly per cycle.
//  Sits between the FFT control top and the dual-port sample RAM / twiddle ROM.
// PARAMETERS
//  N_LOG2    4   log2 of FFT length; N = 1<<N_LOG2, N/2 butterflies per stage
//  PIPE_LAT  2   cycles from rd_en to wr_en (sync RAM read + result register); >=2
// PORTS
//  clk         in   1            single clock, rising edge
//  rst         in   1            synchronous reset, active-high
//  start       in   1            begin transform; sampled only in IDLE
//  stall       in   1            hold issue this cycle (RAM port busy)
//  busy        out  1            high from cycle after accepted start until done pulse
//  done        out  1            1-cycle pulse after final write-back
//  stage       out  N_LOG2       current stage index, 0..N_LOG2-1
//  rd_en       out  1            read strobe for pair (rd_addr_a, rd_addr_b)
//  rd_addr_a   out  N_LOG2       upper-leg address
//  rd_addr_b   out  N_LOG2       lower-leg address (= rd_addr_a + half)
//  tw_addr     out  N_LOG2-1     twiddle ROM index, aligned with rd_en
//  bf_en       out  1            adder 'en': operands valid at adder (rd_en delayed 1)
//  bf_delay    out  1            adder 'delay': keep adder transparent while draining
//  wr_en       out  1            write-back strobe (rd_en delayed PIPE_LAT)
//  wr_addr_a   out  N_LOG2       destination of adder sum output
//  wr_addr_b   out  N_LOG2       destination of adder difference output
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0, delay line cleared (pending writes dropped).
//    Reset mid-transform aborts immediately; no done pulse.
//  - FSM: IDLE -start-> ISSUE; ISSUE -(k==N/2-1 & !stall)-> DRAIN; DRAIN -(cnt==PIPE_LAT-1)->
//    ISSUE (stage+1) or, if stage==N_LOG2-1, DONE; DONE -> IDLE (done=1 for that cycle).
//  - start while not IDLE ignored. start & stall together: start still accepted.
//  - Addressing, stage s, butterfly k (0..N/2-1): half=1<<s; grp=k>>s; pos=k&(half-1);
//    a=(grp<<(s+1))|pos; b=a+half; tw=pos<<(N_LOG2-1-s). All unsigned, no overflow by construction.
//  - ISSUE: rd_en=!stall; k advances only when rd_en. stall holds k, addresses don't care.
//  - Delay line (rd_en,a,b) advances every cycle regardless of stall; bf_en = tap 1,
//    wr_en/wr_addr_a/wr_addr_b = tap PIPE_LAT.
//  - DRAIN: PIPE_LAT cycles, no rd_en, bf_delay=1; guarantees last write of stage s lands
//    before first read of stage s+1 (RAM write visible next cycle). stall ignored in DRAIN.
//  - Latency (no stall): start at cycle t -> first rd_en at t+1; total issue+drain =
//    N_LOG2*(N/2+PIPE_LAT) cycles; done at t+1+N_LOG2*(N/2+PIPE_LAT). Each stall adds 1.
//  - busy deasserts in the same cycle done pulses.
// STRUCTURE
//  - fft_pkg: N_LOG2/PIPE_LAT defaults, FSM state enum (IDLE,ISSUE,DRAIN,DONE), addr width fn.
//  - Sub-module fft_addr_delay: parameterised shift register (valid + two addresses, depth
//    PIPE_LAT, per-tap outputs, sync clear on rst). Address generation/FSM stay in this module.
// TESTING
//  1 N_LOG2=4,PIPE_LAT=2, start@t, no stall -> stage0 pairs (0,1),(2,3)..(14,15) tw=0;
//    stage1 k=1 -> (1,3) tw=4; stage3 k -> (k,k+8) tw=k; done exactly at t+41.
//  2 Alignment: every rd_en pair (a,b) reappears on wr_addr_a/b with wr_en exactly 2 cycles
//    later; bf_en exactly 1 cycle after each rd_en; bf_delay high only in DRAIN.
//  3 stall high 3 cycles mid stage 2 -> no address skipped/duplicated; done at t+44.
//  4 rst asserted at cycle t+20 -> next cycle all outputs 0, no wr_en afterwards, no done;
//    fresh start then completes normally in 40+1 cycles.
//  5 start pulsed during busy and during DONE cycle -> ignored; exactly one done.
//  6 Hazard check with model RAM: last write of each stage precedes next stage's first read.

Source files
------------

// File: rtl/fft_bf_scheduler_pkg.sv
// Shared constants for the radix-2 FFT butterfly scheduler: default geometry,
// FSM state encodings and the twiddle-index width helper.
package fft_bf_scheduler_pkg;

    localparam int unsigned N_LOG2_DEF   = 4;
    localparam int unsigned PIPE_LAT_DEF = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Twiddle index spans N/2 entries; never narrower than one bit.
    function automatic int unsigned tw_width(input int unsigned n_log2);
        return (n_log2 > 1) ? n_log2 - 1 : 1;
    endfunction

endpackage

// File: rtl/fft_bf_scheduler_if.sv
// Control, RAM-read, twiddle, adder-strobe and write-back signals of the
// butterfly scheduler; master is the scheduler, slave is its environment.
interface fft_bf_scheduler_if
    import fft_bf_scheduler_pkg::*;
#(
    parameter int unsigned N_LOG2 = N_LOG2_DEF
);
    localparam int unsigned AW = N_LOG2;
    localparam int unsigned TW = tw_width(N_LOG2);

    logic          start;
    logic          stall;
    logic          busy;
    logic          done;
    logic [AW-1:0] stage;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [TW-1:0] tw_addr;
    logic          bf_en;
    logic          bf_delay;
    logic          wr_en;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;

    modport master (
        input  start, stall,
        output busy, done, stage,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output bf_en, bf_delay,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, stall,
        input  busy, done, stage,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  bf_en, bf_delay,
        input  wr_en, wr_addr_a, wr_addr_b
    );

endinterface

// File: rtl/fft_bf_scheduler_addr_delay.sv
// Shift register carrying the issue strobe and operand-pair addresses from the
// read side to the write-back side; every valid tap is exposed for the adder strobes.
module fft_bf_scheduler_addr_delay #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    input  logic [AW-1:0]    a_in,
    input  logic [AW-1:0]    b_in,
    output logic [DEPTH-1:0] vld_tap,
    output logic [AW-1:0]    a_out,
    output logic [AW-1:0]    b_out
);

    logic [DEPTH-1:0][AW-1:0] a_sr;
    logic [DEPTH-1:0][AW-1:0] b_sr;

    // Advances every cycle; stalls only show up as bubbles in vld_tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_tap <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
        end else begin
            vld_tap[0] <= vld_in;
            a_sr[0]    <= a_in;
            b_sr[0]    <= b_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_tap[i] <= vld_tap[i-1];
                a_sr[i]    <= a_sr[i-1];
                b_sr[i]    <= b_sr[i-1];
            end
        end
    end

    assign a_out = a_sr[DEPTH-1];
    assign b_out = b_sr[DEPTH-1];

endmodule

// File: rtl/fft_bf_scheduler.sv
// Radix-2 in-place FFT butterfly scheduler: walks stages/butterflies one per cycle,
// issues pair reads and twiddle index, and aligns write-back addresses to the adder.
module fft_bf_scheduler
    import fft_bf_scheduler_pkg::*;
#(
    parameter int unsigned N_LOG2   = N_LOG2_DEF,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fft_bf_scheduler_if.master bus
);

    localparam int unsigned AW = N_LOG2;
    localparam int unsigned TW = tw_width(N_LOG2);
    localparam int unsigned CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [TW-1:0]       k;
    logic [TW-1:0]       k_next;
    logic [AW-1:0]       stage;
    logic [AW-1:0]       stage_next;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_next;
    logic                busy_q;
    logic                busy_next;
    logic                done_q;
    logic                done_next;
    logic                drain_q;
    logic                drain_next;
    logic                issue;

    logic [AW-1:0]       k_ext;
    logic [AW-1:0]       half;
    logic [AW-1:0]       pos;
    logic [AW-1:0]       grp;
    logic [AW-1:0]       addr_a;
    logic [AW-1:0]       addr_b;
    logic [TW-1:0]       tw_idx;
    logic                in_issue;
    logic [AW-1:0]       push_a;
    logic [AW-1:0]       push_b;
    logic [PIPE_LAT-1:0] vld_tap;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            k       <= '0;
            stage   <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state   <= state_next;
            k       <= k_next;
            stage   <= stage_next;
            cnt     <= cnt_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
            drain_q <= drain_next;
        end
    end

    // Next-state, counter advance and registered-output decode.
    always_comb begin
        state_next = state;
        k_next     = k;
        stage_next = stage;
        cnt_next   = cnt;
        issue      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_ISSUE;
                    k_next     = '0;
                    stage_next = '0;
                    cnt_next   = '0;
                end
            end
            ST_ISSUE: begin
                issue = !bus.stall;
                if (issue) begin
                    k_next = k + TW'(1);
                    if (&k) begin
                        k_next     = '0;
                        cnt_next   = '0;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Lets the last write of this stage land before the next stage reads.
                if (cnt == CW'(PIPE_LAT - 1)) begin
                    cnt_next = '0;
                    if (stage == AW'(N_LOG2 - 1)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                        stage_next = stage + AW'(1);
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                stage_next = '0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next  = (state_next == ST_ISSUE) || (state_next == ST_DRAIN);
        done_next  = (state_next == ST_DONE);
        drain_next = (state_next == ST_DRAIN);
    end

    // Pair addressing: upper leg has bit 'stage' clear, lower leg sets it.
    always_comb begin
        k_ext  = AW'(k);
        half   = AW'(1) << stage;
        pos    = k_ext & (half - AW'(1));
        grp    = k_ext >> stage;
        addr_a = (grp << (stage + AW'(1))) | pos;
        addr_b = addr_a | half;
        tw_idx = TW'(pos) << (AW'(N_LOG2 - 1) - stage);
    end

    assign in_issue = (state == ST_ISSUE);
    assign push_a   = issue ? addr_a : '0;
    assign push_b   = issue ? addr_b : '0;

    fft_bf_scheduler_addr_delay #(
        .DEPTH (PIPE_LAT),
        .AW    (AW)
    ) u_addr_delay (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (issue),
        .a_in    (push_a),
        .b_in    (push_b),
        .vld_tap (vld_tap),
        .a_out   (bus.wr_addr_a),
        .b_out   (bus.wr_addr_b)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stage;
    assign bus.bf_delay  = drain_q;
    assign bus.rd_en     = issue;
    assign bus.rd_addr_a = in_issue ? addr_a : '0;
    assign bus.rd_addr_b = in_issue ? addr_b : '0;
    assign bus.tw_addr   = in_issue ? tw_idx : '0;
    assign bus.bf_en     = vld_tap[0];
    assign bus.wr_en     = vld_tap[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Bench for fft_bf_scheduler (N=16, PIPE_LAT=2): directed transforms with stalls,
// resets and stray starts, logged at the falling edge and checked against hand values.
module tb_fft_bf_scheduler;

    localparam int NL      = 4;
    localparam int PL      = 2;
    localparam int NB      = 8;
    localparam int STG_CYC = NB + PL;
    localparam int LAT     = 1 + NL * STG_CYC;

    logic clk = 1'b0;
    logic rst;

    fft_bf_scheduler_if #(.N_LOG2(NL)) bus ();

    fft_bf_scheduler #(.N_LOG2(NL), .PIPE_LAT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } ev_t;

    typedef struct {
        int s;
        int k;
        int a;
        int b;
        int tw;
    } vec_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  bf_q[$];
    int  bd_q[$];
    int  done_q[$];
    int  busy_q[$];

    always @(negedge clk) begin
        ev_t e;
        if (bus.rd_en === 1'b1) begin
            e.cyc = cyc; e.a = int'(bus.rd_addr_a); e.b = int'(bus.rd_addr_b);
            e.tw = int'(bus.tw_addr); e.st = int'(bus.stage);
            rd_q.push_back(e);
        end
        if (bus.wr_en === 1'b1) begin
            e.cyc = cyc; e.a = int'(bus.wr_addr_a); e.b = int'(bus.wr_addr_b);
            e.tw = 0; e.st = int'(bus.stage);
            wr_q.push_back(e);
        end
        if (bus.bf_en === 1'b1)    bf_q.push_back(cyc);
        if (bus.bf_delay === 1'b1) bd_q.push_back(cyc);
        if (bus.done === 1'b1)     done_q.push_back(cyc);
        if (bus.busy === 1'b1)     busy_q.push_back(cyc);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int pack(input int c, input int a, input int b, input int tw, input int st);
        return (c << 16) | (a << 12) | (b << 8) | (tw << 4) | st;
    endfunction

    // Upper leg of butterfly k in stage s: the k-th address with bit s clear.
    function automatic int model_a(input int s, input int k);
        int n;
        n = 0;
        for (int x = 0; x < (1 << NL); x++) begin
            if (((x >> s) & 1) == 0) begin
                if (n == k) return x;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic int shifted(input int c, input int t, input int st0, input int slen, input bit shifts);
        return (shifts && c >= t + st0) ? c + slen : c;
    endfunction

    task automatic clear_logs();
        rd_q.delete(); wr_q.delete(); bf_q.delete();
        bd_q.delete(); done_q.delete(); busy_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s busy", tag),      int'(bus.busy),      0);
        chk($sformatf("%s done", tag),      int'(bus.done),      0);
        chk($sformatf("%s stage", tag),     int'(bus.stage),     0);
        chk($sformatf("%s rd_en", tag),     int'(bus.rd_en),     0);
        chk($sformatf("%s rd_addr_a", tag), int'(bus.rd_addr_a), 0);
        chk($sformatf("%s rd_addr_b", tag), int'(bus.rd_addr_b), 0);
        chk($sformatf("%s tw_addr", tag),   int'(bus.tw_addr),   0);
        chk($sformatf("%s bf_en", tag),     int'(bus.bf_en),     0);
        chk($sformatf("%s bf_delay", tag),  int'(bus.bf_delay),  0);
        chk($sformatf("%s wr_en", tag),     int'(bus.wr_en),     0);
        chk($sformatf("%s wr_addr_a", tag), int'(bus.wr_addr_a), 0);
        chk($sformatf("%s wr_addr_b", tag), int'(bus.wr_addr_b), 0);
    endtask

    // One transform over a fixed 60-cycle window; stall window and stray starts relative to t.
    task automatic run_tx(input int st0, input int slen, input int p1, input int p2, output int t);
        clear_logs();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.stall = (slen > 0) && (st0 == 0);
        t = cyc;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            bus.start = (i == p1) || (i == p2);
            bus.stall = (slen > 0) && (i >= st0) && (i < st0 + slen);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic eval_tx(input string tag, input int t, input int st0, input int slen, input bit shifts);
        int sh;
        int ec, ea, eb, etw, d, idx, last_wr, first_rd;
        sh = shifts ? slen : 0;
        chk($sformatf("%s done_count", tag), done_q.size(), 1);
        chk($sformatf("%s done_cycle", tag), (done_q.size() > 0) ? done_q[0] - t : -1, LAT + sh);
        chk($sformatf("%s rd_count", tag), rd_q.size(), NL * NB);
        chk($sformatf("%s wr_count", tag), wr_q.size(), NL * NB);
        chk($sformatf("%s bf_en_count", tag), bf_q.size(), NL * NB);
        chk($sformatf("%s bf_delay_count", tag), bd_q.size(), NL * PL);
        chk($sformatf("%s busy_count", tag), busy_q.size(), NL * STG_CYC + sh);
        chk($sformatf("%s busy_first", tag), (busy_q.size() > 0) ? busy_q[0] - t : -1, 1);
        for (int s = 0; s < NL; s++) begin
            for (int k = 0; k < NB; k++) begin
                idx = s * NB + k;
                ea  = model_a(s, k);
                eb  = ea + (1 << s);
                etw = (ea & ((1 << s) - 1)) << (NL - 1 - s);
                ec  = shifted(t + 1 + s * STG_CYC + k, t, st0, slen, shifts);
                if (idx < rd_q.size())
                    chk($sformatf("%s rd s%0d k%0d", tag, s, k),
                        pack(rd_q[idx].cyc - t, rd_q[idx].a, rd_q[idx].b, rd_q[idx].tw, rd_q[idx].st),
                        pack(ec - t, ea, eb, etw, s));
                if (idx < wr_q.size())
                    chk($sformatf("%s wr s%0d k%0d", tag, s, k),
                        pack(wr_q[idx].cyc - t, wr_q[idx].a, wr_q[idx].b, 0, wr_q[idx].st),
                        pack(ec + PL - t, ea, eb, 0, s));
                if (idx < bf_q.size())
                    chk($sformatf("%s bf_en s%0d k%0d", tag, s, k), bf_q[idx] - t, ec + 1 - t);
            end
            for (int j = 0; j < PL; j++) begin
                idx = s * PL + j;
                d   = shifted(t + 1 + s * STG_CYC + NB + j, t, st0, slen, shifts);
                if (idx < bd_q.size())
                    chk($sformatf("%s bf_delay s%0d j%0d", tag, s, j), bd_q[idx] - t, d - t);
            end
        end
        // RAM hazard: every write of stage s precedes the first read of stage s+1.
        for (int s = 0; s < NL - 1; s++) begin
            last_wr  = -1;
            first_rd = 1 << 30;
            foreach (wr_q[i]) if (wr_q[i].st == s && wr_q[i].cyc > last_wr) last_wr = wr_q[i].cyc;
            foreach (rd_q[i]) if (rd_q[i].st == s + 1 && rd_q[i].cyc < first_rd) first_rd = rd_q[i].cyc;
            chk($sformatf("%s hazard s%0d", tag, s), (last_wr >= 0 && last_wr < first_rd) ? 1 : 0, 1);
        end
    endtask

    initial begin
        vec_t tbl[13];
        int   t;
        int   idx;
        int   act;
        int   n;

        tbl[0]  = '{0, 0,  0,  1, 0};
        tbl[1]  = '{0, 3,  6,  7, 0};
        tbl[2]  = '{0, 7, 14, 15, 0};
        tbl[3]  = '{1, 0,  0,  2, 0};
        tbl[4]  = '{1, 1,  1,  3, 4};
        tbl[5]  = '{1, 5,  9, 11, 4};
        tbl[6]  = '{1, 7, 13, 15, 4};
        tbl[7]  = '{2, 3,  3,  7, 6};
        tbl[8]  = '{2, 5,  9, 13, 2};
        tbl[9]  = '{2, 6, 10, 14, 4};
        tbl[10] = '{3, 0,  0,  8, 0};
        tbl[11] = '{3, 6,  6, 14, 6};
        tbl[12] = '{3, 7,  7, 15, 7};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        run_tx(0, 0, -1, -1, t);
        eval_tx("plain", t, 0, 0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            idx = tbl[i].s * NB + tbl[i].k;
            act = (idx < rd_q.size()) ? pack(0, rd_q[idx].a, rd_q[idx].b, rd_q[idx].tw, rd_q[idx].st) : -1;
            chk($sformatf("table s%0d k%0d", tbl[i].s, tbl[i].k), act,
                pack(0, tbl[i].a, tbl[i].b, tbl[i].tw, tbl[i].s));
        end

        run_tx(23, 3, -1, -1, t);
        eval_tx("stall_s2", t, 23, 3, 1'b1);

        run_tx(0, 1, -1, -1, t);
        eval_tx("start_with_stall", t, 0, 1, 1'b0);

        run_tx(9, 2, -1, -1, t);
        eval_tx("stall_in_drain", t, 9, 2, 1'b0);

        // Reset in the middle of a transform.
        clear_logs();
        @(posedge clk); #1;
        bus.start = 1'b1;
        t = cyc;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (i == 20) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("rst_mid");
        repeat (40) @(posedge clk);
        #1;
        n = 0;
        foreach (wr_q[i]) if (wr_q[i].cyc > t + 20) n++;
        chk("rst_mid wr_after_reset", n, 0);
        chk("rst_mid done_count", done_q.size(), 0);
        chk("rst_mid busy_idle", int'(bus.busy), 0);

        run_tx(0, 0, -1, -1, t);
        eval_tx("after_rst", t, 0, 0, 1'b0);

        run_tx(0, 0, 5, LAT, t);
        eval_tx("start_ignored", t, 0, 0, 1'b0);
        chk("start_ignored busy_end", int'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
